// File: rtl/expr_equiv_checker.sv
// Exhaustive-sweep equivalence checker for five original/simplified boolean expression pairs.
// Optional fault injection on the simplified output is enabled by defining EXPR_EQUIV_FAULT_INJ_EN.
`timescale 1ns/1ps

module expr_equiv_checker #(
  parameter int unsigned NVARS  = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       sel,
`ifdef EXPR_EQUIV_FAULT_INJ_EN
  input  logic             inj_en,
  input  logic [NVARS-1:0] inj_vec,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             bad_sel,
  output logic [NVARS:0]   err_cnt,
  output logic [NVARS-1:0] first_bad,
  output logic             first_bad_vld,
  output logic [NVARS-1:0] vec,
  output logic             s_orig,
  output logic             s_simp
);

  localparam int unsigned ERRW = NVARS + 1;
  localparam int unsigned CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [NVARS-1:0] VEC_LAST = '1;
  localparam logic [2:0]       SEL_MAX  = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [2:0]       sel_q, sel_q_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [NVARS-1:0] vec_d;
  logic [NVARS:0]   err_cnt_d;
  logic [NVARS-1:0] first_bad_d;
  logic             first_bad_vld_d;
  logic             pass_d, bad_sel_d, busy_d, done_d;
  logic             x, y, simp_raw;

`ifdef EXPR_EQUIV_FAULT_INJ_EN
  logic             inj_en_q, inj_en_q_d;
  logic [NVARS-1:0] inj_vec_q, inj_vec_q_d;
`endif

  assign x = vec[NVARS-1];
  assign y = vec[NVARS-2];

  // Expression pairs evaluated on the currently applied vector
  always_comb begin
    s_orig   = 1'b0;
    simp_raw = 1'b0;
    case (sel_q)
      3'd0: begin
        s_orig   = x & ~(~x | y);
        simp_raw = x & ~y;
      end
      3'd1: begin
        s_orig   = (~x | y) | (~x & y);
        simp_raw = ~x | y;
      end
      3'd2: begin
        s_orig   = ~(~x & ~y) & (x | y);
        simp_raw = x | y;
      end
      3'd3: begin
        s_orig   = ~(~x & y) | ~(~x | y);
        simp_raw = x | ~y;
      end
      3'd4: begin
        s_orig   = (y | ~x) & ~(~y | x);
        simp_raw = ~x & y;
      end
      default: begin
        s_orig   = 1'b0;
        simp_raw = 1'b0;
      end
    endcase
  end

`ifdef EXPR_EQUIV_FAULT_INJ_EN
  assign s_simp = (inj_en_q && (vec == inj_vec_q)) ? ~simp_raw : simp_raw;
`else
  assign s_simp = simp_raw;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state;
    sel_q_d         = sel_q;
    cnt_d           = cnt;
    vec_d           = vec;
    err_cnt_d       = err_cnt;
    first_bad_d     = first_bad;
    first_bad_vld_d = first_bad_vld;
    pass_d          = pass;
    bad_sel_d       = bad_sel;
    busy_d          = busy;
    done_d          = 1'b0;
`ifdef EXPR_EQUIV_FAULT_INJ_EN
    inj_en_q_d      = inj_en_q;
    inj_vec_q_d     = inj_vec_q;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          sel_q_d         = sel;
          vec_d           = '0;
          err_cnt_d       = '0;
          first_bad_d     = '0;
          first_bad_vld_d = 1'b0;
          pass_d          = 1'b0;
          bad_sel_d       = (sel > SEL_MAX);
          busy_d          = 1'b1;
          cnt_d           = CW'(SETTLE - 1);
`ifdef EXPR_EQUIV_FAULT_INJ_EN
          inj_en_q_d      = inj_en;
          inj_vec_q_d     = inj_vec;
`endif
          if (sel > SEL_MAX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (cnt == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end

      CHECK: begin
        if (s_orig != s_simp) begin
          err_cnt_d = err_cnt + ERRW'(1);
          if (!first_bad_vld) begin
            first_bad_d     = vec;
            first_bad_vld_d = 1'b1;
          end
        end
        if (vec == VEC_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          vec_d   = vec + NVARS'(1);
          cnt_d   = CW'(SETTLE - 1);
          state_d = RUN;
        end
      end

      DONE: begin
        pass_d  = (err_cnt == '0) && !bad_sel;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sel_q         <= '0;
      cnt           <= '0;
      vec           <= '0;
      err_cnt       <= '0;
      first_bad     <= '0;
      first_bad_vld <= 1'b0;
      pass          <= 1'b0;
      bad_sel       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef EXPR_EQUIV_FAULT_INJ_EN
      inj_en_q      <= 1'b0;
      inj_vec_q     <= '0;
`endif
    end else begin
      state         <= state_d;
      sel_q         <= sel_q_d;
      cnt           <= cnt_d;
      vec           <= vec_d;
      err_cnt       <= err_cnt_d;
      first_bad     <= first_bad_d;
      first_bad_vld <= first_bad_vld_d;
      pass          <= pass_d;
      bad_sel       <= bad_sel_d;
      busy          <= busy_d;
      done          <= done_d;
`ifdef EXPR_EQUIV_FAULT_INJ_EN
      inj_en_q      <= inj_en_q_d;
      inj_vec_q     <= inj_vec_q_d;
`endif
    end
  end

endmodule
